// File: rtl/imem_pkg.sv
// Shared types, widths and address-decode helpers for the instruction-fetch responder.
package imem_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // The address must be word aligned and fall inside [base, base + 4*depth).
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned depth);
    logic [31:0] span;
    logic [31:0] off;
    span = depth << 2;
    off  = addr - base;
    return (addr[1:0] == 2'b00) && (addr >= base) && (off < span);
  endfunction

  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return off >> 2;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word storage: one synchronous read port and one write port; a read and a write
// to the same word in the same cycle return the old word.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic            rd_zero,
  input  logic [AW-1:0]   rd_idx,
  output logic [ILEN-1:0] rd_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_idx,
  input  logic [ILEN-1:0] wr_data
);

  logic [ILEN-1:0] mem [DEPTH];

  // Storage write; contents deliberately survive reset so a preload is kept.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Read register: loads on a good fetch, clears on a faulting fetch, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= {ILEN{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end else if (rd_zero) begin
      rd_data <= {ILEN{1'b0}};
    end else begin
      rd_data <= rd_data;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts one request at a time, waits LATENCY cycles,
// then holds a single word (or an access fault) until the core takes it.
module imem_responder
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ILEN-1:0] rsp_data,
  output logic            rsp_err,
  input  logic            wr_en,
  input  logic [31:0]     wr_addr,
  input  logic [ILEN-1:0] wr_data,
  output logic [31:0]     fetch_count
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam logic [3:0]  LAT = 4'(LATENCY);

  state_t        state;
  logic [3:0]    wait_cnt;
  logic          accept;
  logic          req_ok;
  logic          wr_ok;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign req_ok    = addr_in_range(req_addr, BASE_ADDR, DEPTH);
  assign wr_ok     = wr_en && addr_in_range(wr_addr, BASE_ADDR, DEPTH);
  assign rd_idx    = AW'(word_index(req_addr, BASE_ADDR));
  assign wr_idx    = AW'(word_index(wr_addr, BASE_ADDR));

  // The array's read register doubles as rsp_data, so the snapshot taken at
  // accept is held untouched until the next accept.
  imem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (accept && req_ok),
    .rd_zero (accept && !req_ok),
    .rd_idx  (rd_idx),
    .rd_data (rsp_data),
    .wr_en   (wr_ok),
    .wr_idx  (wr_idx),
    .wr_data (wr_data)
  );

  // Fetch FSM with registered response flags and handshake counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_err <= !req_ok;
            if (LAT == 4'd0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state    <= WAIT;
              wait_cnt <= LAT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state       <= IDLE;
            rsp_valid   <= 1'b0;
            fetch_count <= fetch_count + 32'd1;
          end else begin
            state <= RESP;
          end
        end
        default: begin
          state     <= IDLE;
          wait_cnt  <= 4'd0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
